// File: rtl/tlc_pkg.sv
// Shared types and light encodings for the traffic-light controller.
// NIGHT_FLASH exists only when TLC_NIGHT_MODE_EN is defined.
package tlc_pkg;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED1  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED2  = 3'd5,
      PED_WALK  = 3'd6
`ifdef TLC_NIGHT_MODE_EN
      , NIGHT_FLASH = 3'd7
`endif
   } state_t;

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_OFF = 3'b000;

   function automatic int max4(input int a, input int b,
                               input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Turns the divider's slow_clk level into a one-cycle tick on each
// rising edge, sampled in the clk_in domain.
module tick_edge_det (
   input  logic clk_in,
   input  logic rst,
   input  logic slow_clk,
   output logic tick
);

   logic slow_q;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) slow_q <= 1'b0;
      else     slow_q <= slow_clk;
   end

   assign tick = slow_clk & ~slow_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// NS/EW traffic-light controller with pedestrian phase.
// Optional night-flash mode: define TLC_NIGHT_MODE_EN.
module traffic_light_fsm
   import tlc_pkg::*;
#(
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 4,
   parameter int RED_T    = 2,
   parameter int PED_T    = 8
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       slow_clk,
   input  logic       ped_req,
   input  logic       night,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk
);

   localparam int MAXD = max4(GREEN_T, YELLOW_T, RED_T, PED_T);
   localparam int TW   = $clog2(MAXD) + 1;

   state_t          state, state_n;
   logic [TW-1:0]   timer, timer_n;
   logic            ped_pending, pend_n;
   logic            tick, advance;
   logic [2:0]      ns_n, ew_n;
   logic            walk_n;
   logic            flash, flash_n;

   function automatic logic [TW-1:0] load(input state_t s);
      logic [TW-1:0] v;
      v = TW'(RED_T - 1);
      case (s)
         NS_GREEN, EW_GREEN:   v = TW'(GREEN_T - 1);
         NS_YELLOW, EW_YELLOW: v = TW'(YELLOW_T - 1);
         PED_WALK:             v = TW'(PED_T - 1);
         default:              v = TW'(RED_T - 1);
      endcase
      return v;
   endfunction

   tick_edge_det u_tick (
      .clk_in   (clk_in),
      .rst      (rst),
      .slow_clk (slow_clk),
      .tick     (tick)
   );

`ifndef TLC_NIGHT_MODE_EN
   logic unused_night;
   assign unused_night = night;
`endif

   assign advance = tick && (timer == '0);

   always_comb begin
      state_n = state;
      timer_n = timer;
      flash_n = flash;
      pend_n  = ped_pending | ped_req;
      unique case (state)
         NS_GREEN:  if (advance) state_n = NS_YELLOW;
         NS_YELLOW: if (advance) state_n = ALL_RED1;
         ALL_RED1: begin
`ifdef TLC_NIGHT_MODE_EN
            if (tick && night) state_n = NIGHT_FLASH;
            else
`endif
            if (advance) state_n = EW_GREEN;
         end
         EW_GREEN:  if (advance) state_n = EW_YELLOW;
         EW_YELLOW: if (advance) state_n = ALL_RED2;
         ALL_RED2: begin
`ifdef TLC_NIGHT_MODE_EN
            if (tick && night) state_n = NIGHT_FLASH;
            else
`endif
            if (advance) state_n = ped_pending ? PED_WALK : NS_GREEN;
         end
         PED_WALK:  if (advance) state_n = NS_GREEN;
`ifdef TLC_NIGHT_MODE_EN
         NIGHT_FLASH: begin
            if (tick && !night) state_n = ALL_RED2;
            else if (tick)      flash_n = ~flash;
         end
`endif
         default:   state_n = ALL_RED2;
      endcase

      // Any state change (including illegal recovery) reloads the timer.
      if (state_n != state) begin
         timer_n = load(state_n);
         flash_n = 1'b1;
      end else if (tick && timer != '0) begin
         timer_n = timer - 1'b1;
      end

      // Request seen on the entry edge is absorbed by this walk.
      if (state_n == PED_WALK && state != PED_WALK) pend_n = 1'b0;

      ns_n   = L_RED;
      ew_n   = L_RED;
      walk_n = 1'b0;
      case (state_n)
         NS_GREEN:  ns_n = L_GRN;
         NS_YELLOW: ns_n = L_YEL;
         EW_GREEN:  ew_n = L_GRN;
         EW_YELLOW: ew_n = L_YEL;
         PED_WALK:  walk_n = 1'b1;
`ifdef TLC_NIGHT_MODE_EN
         NIGHT_FLASH: begin
            ns_n = flash_n ? L_YEL : L_OFF;
            ew_n = flash_n ? L_YEL : L_OFF;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state       <= ALL_RED2;
         timer       <= TW'(RED_T - 1);
         ped_pending <= 1'b0;
         flash       <= 1'b0;
         ns_light    <= L_RED;
         ew_light    <= L_RED;
         walk        <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         ped_pending <= pend_n;
         flash       <= flash_n;
         ns_light    <= ns_n;
         ew_light    <= ew_n;
         walk        <= walk_n;
      end
   end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with short phase durations.
// Night-flash steps run only when TLC_NIGHT_MODE_EN is defined.
module tb_traffic_light_fsm;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       slow_clk;
   logic       ped_req;
   logic       night;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [6:0] NSG = {3'b001, 3'b100, 1'b0};
   localparam logic [6:0] NSY = {3'b010, 3'b100, 1'b0};
   localparam logic [6:0] EWG = {3'b100, 3'b001, 1'b0};
   localparam logic [6:0] EWY = {3'b100, 3'b010, 1'b0};
   localparam logic [6:0] AR  = {3'b100, 3'b100, 1'b0};
   localparam logic [6:0] PW  = {3'b100, 3'b100, 1'b1};
   localparam logic [6:0] FON = {3'b010, 3'b010, 1'b0};
   localparam logic [6:0] FOF = {3'b000, 3'b000, 1'b0};

   traffic_light_fsm #(
      .GREEN_T (3),
      .YELLOW_T(2),
      .RED_T   (1),
      .PED_T   (2)
   ) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .slow_clk(slow_clk),
      .ped_req (ped_req),
      .night   (night),
      .ns_light(ns_light),
      .ew_light(ew_light),
      .walk    (walk)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {ns_light, ew_light, walk};
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_pend(input string tag, input logic exp);
      logic obs;
      obs = dut.ped_pending;
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b required=%b", tag, obs, exp);
      end
   endtask

   // pmode: 0 none, 1 ped_req on the tick cycle only, 2 held one more cycle
   task automatic do_tick(input int pmode);
      @(negedge clk_in);
      slow_clk = 1'b1;
      if (pmode != 0) ped_req = 1'b1;
      @(negedge clk_in);
      if (pmode == 1) ped_req = 1'b0;
      @(negedge clk_in);
      slow_clk = 1'b0;
      ped_req  = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic pulse_ped();
      @(negedge clk_in);
      ped_req = 1'b1;
      @(negedge clk_in);
      ped_req = 1'b0;
   endtask

   task automatic run_to_ar2(input string tag);
      logic [6:0] seq [11];
      seq = '{NSG, NSG, NSY, NSY, AR, EWG, EWG, EWG, EWY, EWY, AR};
      for (int i = 0; i < 11; i++) begin
         do_tick(0);
         chk($sformatf("%s_t%0d", tag, i), seq[i]);
      end
   endtask

   initial begin
      rst      = 1'b1;
      slow_clk = 1'b0;
      ped_req  = 1'b0;
      night    = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("reset_hold", AR);
      rst = 1'b0;
      @(negedge clk_in);
      chk("reset_release", AR);
      chk_pend("reset_pend", 1'b0);
      do_tick(0);
      chk("first_tick", NSG);

      // asynchronous reset in the middle of a clock period
      @(posedge clk_in);
      #2 rst = 1'b1;
      #1 chk("async_rst", AR);
      @(negedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      chk("async_rst_hold", AR);
      do_tick(0);
      chk("after_async", NSG);

      // full round, no pedestrian
      run_to_ar2("round0");
      do_tick(0);
      chk("round0_back", NSG);
      chk_pend("round0_pend", 1'b0);

      // single ped pulse during NS_GREEN
      pulse_ped();
      chk_pend("ped_latched", 1'b1);
      run_to_ar2("round1");
      do_tick(0);
      chk("walk1_a", PW);
      do_tick(0);
      chk("walk1_b", PW);
      do_tick(0);
      chk("walk1_end", NSG);
      chk_pend("walk1_pend", 1'b0);

      // ped held across walk entry -> re-latched
      pulse_ped();
      run_to_ar2("round2");
      @(negedge clk_in);
      ped_req = 1'b1;
      do_tick(2);
      chk("held_walk_a", PW);
      chk_pend("held_relatch", 1'b1);
      do_tick(0);
      chk("held_walk_b", PW);
      do_tick(0);
      chk("held_walk_end", NSG);
      run_to_ar2("round3");
      do_tick(0);
      chk("second_walk_a", PW);
      do_tick(0);
      chk("second_walk_b", PW);
      do_tick(0);
      chk("second_walk_end", NSG);
      chk_pend("second_walk_pend", 1'b0);

      // ped only on the entry cycle -> absorbed
      pulse_ped();
      run_to_ar2("round4");
      do_tick(1);
      chk("entry_walk_a", PW);
      chk_pend("entry_absorbed", 1'b0);
      do_tick(0);
      chk("entry_walk_b", PW);
      do_tick(0);
      chk("entry_walk_end", NSG);
      run_to_ar2("round5");
      do_tick(0);
      chk("no_second_walk", NSG);

      // slow_clk held high 10 cycles -> one tick
      @(negedge clk_in);
      slow_clk = 1'b1;
      repeat (10) @(negedge clk_in);
      slow_clk = 1'b0;
      @(negedge clk_in);
      chk("long_high", NSG);
      do_tick(0);
      chk("long_high_t1", NSG);
      do_tick(0);
      chk("long_high_t2", NSY);

      // reset while slow_clk is high
      @(negedge clk_in);
      slow_clk = 1'b1;
      rst      = 1'b1;
      @(negedge clk_in);
      chk("rst_slow_high", AR);
      @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      chk("rst_slow_first", NSG);
      repeat (8) @(negedge clk_in);
      slow_clk = 1'b0;
      @(negedge clk_in);
      chk("rst_slow_once", NSG);
      do_tick(0);
      chk("rst_slow_t1", NSG);
      do_tick(0);
      chk("rst_slow_t2", NSG);
      do_tick(0);
      chk("rst_slow_t3", NSY);

`ifdef TLC_NIGHT_MODE_EN
      do_tick(0);
      chk("nt_nsy", NSY);
      do_tick(0);
      chk("nt_ar1", AR);
      do_tick(0);
      chk("nt_ewg", EWG);
      night = 1'b1;
      do_tick(0);
      chk("nt_ewg_1", EWG);
      do_tick(0);
      chk("nt_ewg_2", EWG);
      do_tick(0);
      chk("nt_ewy_1", EWY);
      do_tick(0);
      chk("nt_ewy_2", EWY);
      do_tick(0);
      chk("nt_ar2", AR);
      do_tick(0);
      chk("nt_flash_on", FON);
      do_tick(0);
      chk("nt_flash_off", FOF);
      do_tick(0);
      chk("nt_flash_on2", FON);
      night = 1'b0;
      do_tick(0);
      chk("nt_exit_red", AR);
      do_tick(0);
      chk("nt_exit_nsg", NSG);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
